// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES-192 round-key schedule controller.
// The round-key buffer is always 16 deep so rk_idx can address it directly.
package aes_pkg;

    localparam int KEY_W     = 192;
    localparam int BLK_W     = 128;
    localparam int NUM_KEYS  = 13;
    localparam int BUF_DEPTH = 16;
    localparam int IDX_W     = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } ks_state_e;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int num_keys);
        return int'(idx) < num_keys;
    endfunction

endpackage

// File: rtl/aes_rk_buf.sv
// Round-key storage: 16x128 with one write port and one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module aes_rk_buf
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [BLK_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [BLK_W-1:0] rdata_o
);

    logic [BLK_W-1:0] mem_q [BUF_DEPTH];
    logic [BLK_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Controller around an external AES-192 key-expansion core: accepts a cipher key,
// kicks the core, captures its round-key burst and serves round keys by index.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = aes_pkg::NUM_KEYS,
    parameter int TIMEOUT  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_ready,
    output logic             exp_start,
    output logic [KEY_W-1:0] exp_key,
    input  logic [BLK_W-1:0] exp_subkey,
    input  logic             exp_rdy,
    input  logic [IDX_W-1:0] rk_idx,
    output logic [BLK_W-1:0] rk_out,
    output logic             keys_valid,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(NUM_KEYS + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_KEYS);
    // The exp_start cycle is the first of the TIMEOUT cycles and the ERR
    // transition takes one more edge, hence the last waiting count is TIMEOUT-2.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

    ks_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [KEY_W-1:0]   exp_key_q, exp_key_d;
    logic               rd_sel_q;
    logic               handshake;
    logic               buf_we;
    logic [IDX_W-1:0]   buf_waddr;
    logic [BLK_W-1:0]   buf_rdata;

    assign key_ready  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign exp_start  = (state_q == S_START);
    assign busy       = (state_q == S_START) || (state_q == S_CAPTURE);
    assign keys_valid = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign exp_key    = exp_key_q;
    assign handshake  = key_valid && key_ready;
    assign buf_waddr  = IDX_W'(cnt_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        exp_key_d = exp_key_q;
        buf_we    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (handshake) begin
                    exp_key_d = key_in;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (exp_rdy) begin
                    buf_we = (cnt_q != CNT_MAX);
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end else if (cnt_q != '0) begin
                    // The core delivers its burst back to back; a gap means a short burst.
                    state_d = S_ERR;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            exp_key_q <= '0;
            rd_sel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            exp_key_q <= exp_key_d;
            rd_sel_q  <= keys_valid && idx_in_range(rk_idx, NUM_KEYS);
        end
    end

    aes_rk_buf u_rk_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (exp_subkey),
        .raddr_i (rk_idx),
        .rdata_o (buf_rdata)
    );

    // Gating with the live keys_valid hides stale data the moment a new key is taken.
    assign rk_out = (rd_sel_q && keys_valid) ? buf_rdata : '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural AES-192 key-expansion core.
module tb_aes_key_sched_ctrl;

    localparam logic [191:0] KEY_A  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] RK_A0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] RK_A1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] RK_A12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [191:0] KEY_B  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] RK_B0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK_B1  = 128'h10111213141516175846f2f95c43f4fe;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [191:0] key_in;
    logic         key_ready;
    logic         exp_start;
    logic [191:0] exp_key;
    logic [127:0] exp_subkey;
    logic         exp_rdy;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         keys_valid;
    logic         busy;
    logic         err;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int snap;
    logic [127:0] model_rk [13];

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .exp_start  (exp_start),
        .exp_key    (exp_key),
        .exp_subkey (exp_subkey),
        .exp_rdy    (exp_rdy),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .keys_valid (keys_valid),
        .busy       (busy),
        .err        (err)
    );

    always @(posedge clk) begin
        if (exp_start === 1'b1) start_cnt++;
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk192(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // ---- behavioural AES-192 key expansion ----
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [191:0] k);
        logic [31:0] w [52];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 6; i++) w[i] = k[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---- stimulus helpers (drive just after negedge, sample at negedge) ----
    task automatic give_key(input logic [191:0] k, input bit hold);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        if (!hold) key_valid = 1'b0;
    endtask

    // Core model: wait for exp_start, idle lat cycles, then stream n round keys.
    task automatic serve(input int lat, input int n);
        int w;
        w = 0;
        while (exp_start !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk1("start_seen", exp_start, 1'b1);
        for (int j = 0; j < lat; j++) begin
            @(negedge clk);
            if (j == 0) chk1("start_one_cycle", exp_start, 1'b0);
        end
        for (int k = 0; k < n; k++) begin
            exp_rdy    = 1'b1;
            exp_subkey = model_rk[k];
            if (k == n - 1) key_valid = 1'b0;
            @(negedge clk);
        end
        exp_rdy    = 1'b0;
        exp_subkey = '0;
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] expv);
        rk_idx = idx;
        @(negedge clk);
        chk128(tag, rk_out, expv);
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < 13; i++) begin
            rk_idx = 4'(i);
            @(negedge clk);
            chk128($sformatf("%s_rk%0d", tag, i), rk_out, model_rk[i]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_in     = '0;
        exp_rdy    = 1'b0;
        exp_subkey = '0;
        rk_idx     = 4'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_keys_valid", keys_valid, 1'b0);
        chk1("rst_exp_start", exp_start, 1'b0);
        chk192("rst_exp_key", exp_key, '0);
        chk128("rst_rk_out", rk_out, '0);
        reset = 1'b0;
        @(negedge clk);
        chk1("post_rst_key_ready", key_ready, 1'b1);

        // Full expansion of the FIPS-197 AES-192 key
        expand_key(KEY_A);
        chk128("model_a_rk0", model_rk[0], RK_A0);
        chk128("model_a_rk12", model_rk[12], RK_A12);
        snap = start_cnt;
        give_key(KEY_A, 1'b0);
        chk1("a_busy", busy, 1'b1);
        chk1("a_key_ready_busy", key_ready, 1'b0);
        chk192("a_exp_key", exp_key, KEY_A);
        serve(3, 13);
        chk1("a_keys_valid", keys_valid, 1'b1);
        chk1("a_busy_done", busy, 1'b0);
        chk1("a_err", err, 1'b0);
        chk1("a_key_ready_done", key_ready, 1'b1);
        chkint("a_start_pulses", start_cnt - snap, 1);
        rd("a_rk0", 4'd0, RK_A0);
        rd("a_rk1", 4'd1, RK_A1);
        rd("a_rk12", 4'd12, RK_A12);
        rd("a_idx13", 4'd13, '0);
        rd("a_idx15", 4'd15, '0);
        rd("a_b2b3", 4'd3, model_rk[3]);
        rd("a_b2b4", 4'd4, model_rk[4]);
        rd("a_b2b5", 4'd5, model_rk[5]);
        readback_all("a");
        chk192("a_exp_key_hold", exp_key, KEY_A);

        // New key accepted in DONE, key_valid held through the capture
        rk_idx = 4'd2;
        snap = start_cnt;
        give_key(KEY_B, 1'b1);
        chk1("b_keys_valid_drop", keys_valid, 1'b0);
        chk128("b_rk_out_masked", rk_out, '0);
        chk192("b_exp_key", exp_key, KEY_B);
        expand_key(KEY_B);
        serve(2, 13);
        chk1("b_keys_valid", keys_valid, 1'b1);
        chkint("b_start_pulses", start_cnt - snap, 1);
        rd("b_rk0", 4'd0, RK_B0);
        rd("b_rk1", 4'd1, RK_B1);
        readback_all("b");

        // Core never answers: err exactly TIMEOUT cycles after exp_start
        expand_key(KEY_A);
        give_key(KEY_A, 1'b0);
        chk1("to_start", exp_start, 1'b1);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            chk1($sformatf("to_wait%0d", i), err, 1'b0);
        end
        @(negedge clk);
        chk1("to_err", err, 1'b1);
        chk1("to_busy", busy, 1'b0);
        chk1("to_key_ready", key_ready, 1'b1);
        chk1("to_keys_valid", keys_valid, 1'b0);

        // Short burst: exp_rdy drops after 5 subkeys
        give_key(KEY_A, 1'b0);
        chk1("sb_err_cleared", err, 1'b0);
        serve(2, 5);
        @(negedge clk);
        chk1("sb_err", err, 1'b1);
        chk1("sb_keys_valid", keys_valid, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            @(negedge clk);
            chk128($sformatf("sb_zero%0d", i), rk_out, '0);
        end

        // Reset mid-capture overriding a concurrent handshake, then re-run
        snap = start_cnt;
        give_key(KEY_A, 1'b0);
        serve(2, 7);
        reset     = 1'b1;
        key_valid = 1'b1;
        key_in    = KEY_B;
        @(negedge clk);
        chk1("mr_busy", busy, 1'b0);
        chk192("mr_exp_key", exp_key, '0);
        reset     = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        chk1("mr_key_ready", key_ready, 1'b1);
        chk1("mr_idle_busy", busy, 1'b0);
        chk1("mr_keys_valid", keys_valid, 1'b0);
        chk192("mr_no_handshake", exp_key, '0);
        give_key(KEY_A, 1'b0);
        serve(1, 13);
        chk1("mr_keys_valid_done", keys_valid, 1'b1);
        chkint("mr_start_pulses", start_cnt - snap, 2);
        readback_all("mr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 13, meaning round keys captured per expansion (AES-192).
REQ-002 SHALL have parameter TIMEOUT, default 32, meaning max cycles from exp_start to first exp_rdy.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_valid, input, 1, requester offers a new cipher key.
REQ-006 SHALL have port key_in, input, 192, cipher key, sampled when key_valid && key_ready.
REQ-007 SHALL have port key_ready, output, 1, controller can accept a key.
REQ-008 SHALL have ports exp_start (output, 1), exp_key (output, 192), exp_subkey (input, 128) and exp_rdy (input, 1), connecting to the AESKeyexpansion_192 core.
REQ-009 SHALL have port rk_idx, input, 4, round-key read index.
REQ-010 SHALL have port rk_out, output, 128, round key at rk_idx.
REQ-011 SHALL have ports keys_valid (output, 1, full key set stored), busy (output, 1, expansion running) and err (output, 1, timeout or short burst).

Function
REQ-012 SHALL implement states IDLE, START, CAPTURE, DONE, ERR.
REQ-013 SHALL assert key_ready only in IDLE, DONE and ERR.
REQ-014 SHALL, on a key_valid && key_ready handshake, latch key_in into exp_key, clear keys_valid and err, and go to START.
REQ-015 SHALL, in START, drive exp_start high for exactly one cycle, clear the capture counter and the timeout counter, and go to CAPTURE.
REQ-016 SHALL hold exp_key stable from the handshake until the next accepted key.
REQ-017 SHALL, in CAPTURE, write exp_subkey into buffer entry cnt on each cycle exp_rdy is high, then increment cnt.
REQ-018 SHALL store entries in arrival order: entry 0 = key[191:64], entry 1 = key[63:0] || w6 || w7, ..., entry 12 = last round key.
REQ-019 SHALL go from CAPTURE to DONE and assert keys_valid in the cycle after entry NUM_KEYS-1 is written.
REQ-020 SHALL go to ERR if no exp_rdy arrives within TIMEOUT cycles of exp_start.
REQ-021 SHALL go to ERR if exp_rdy deasserts after the first capture but before NUM_KEYS captures.
REQ-022 SHALL ignore exp_rdy outside CAPTURE.
REQ-023 SHALL hold busy high in START and CAPTURE, and low otherwise.
REQ-024 SHALL register rk_out with 1-cycle latency: rk_out(t+1) = buf[rk_idx(t)].
REQ-025 SHALL drive rk_out to 0 when rk_idx >= NUM_KEYS.
REQ-026 SHALL drive rk_out to 0 whenever keys_valid is low, including during re-expansion.
REQ-027 SHALL allow a new key handshake in DONE; this clears keys_valid in the same cycle as the handshake.
REQ-028 SHALL ignore key_valid while busy; key_ready is low, so no handshake occurs.
REQ-029 SHALL size cnt and the timeout counter as ceil(log2) of their maxima.
REQ-030 SHALL stop cnt from wrapping past NUM_KEYS.

Reset
REQ-031 SHALL, when reset is high at a clock edge, go to IDLE and clear keys_valid, err, busy, exp_start, rk_out, exp_key, cnt and the timeout counter.
REQ-032 SHALL let reset override any concurrent handshake.
REQ-033 SHALL, on reset mid-CAPTURE, discard the partial key set; the buffer contents need not be cleared.
REQ-034 SHALL make key_ready high in the first cycle after reset deasserts.

Structure
REQ-035 SHALL place the state encoding, KEY_W=192, BLK_W=128 and NUM_KEYS in a shared package aes_pkg.
REQ-036 SHALL implement the round-key buffer as one sub-module, aes_rk_buf: 16x128 storage with 1 write port and 1 registered read port.
REQ-037 SHALL not instantiate the expansion core; it is connected at the top level.

Verification
REQ-038 SHALL verify: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b with the real core -> keys_valid high; rk_idx 0 -> 8e73b0f7da0e6452c810f32b809079e5; rk_idx 1 -> 62f8ead2522c6b7bfe0c91f72402f5a5; rk_idx 12 -> e98ba06f448c773c8ecc720401002202.
REQ-039 SHALL verify: stub core never asserts exp_rdy -> err high exactly 32 cycles after exp_start, busy low and key_ready high.
REQ-040 SHALL verify: stub drops exp_rdy after 5 subkeys -> ERR, keys_valid low, rk_out 0 for all indices.
REQ-041 SHALL verify: reset pulsed at capture 7, then the same key reapplied -> correct 13 keys; exp_start pulses exactly once per handshake.
REQ-042 SHALL verify: key_valid held high during CAPTURE -> no second exp_start; a new key accepted in DONE -> keys_valid drops the next cycle and the new set is read back correctly.
REQ-043 SHALL verify: rk_idx 13 and 15 in DONE -> rk_out 0; back-to-back idx 3,4,5 -> outputs follow with 1-cycle latency.
